cpu_ctrl_seq: RTL and testbench

Parametrised control sequencer for the 8-bit CPU; successor to the two-state fetch/execute controller. Adds continuous-run and single-step modes, flag-conditional branches, a load/store memory phase with a req/ack handshake, and a HALT state. It sits between the instruction register / flag register and the PC, ALU, A/X register file and data-memory port.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/cpu_ctrl_mem_timer.sv | 33 +++
 rtl/cpu_ctrl_seq.sv | 186 ++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: state encoding, ALU and
// control-class opcodes, and the ALU write-target table. FAULT needs CPU_CTRL_TIMEOUT_EN.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
`ifdef CPU_CTRL_TIMEOUT_EN
    ,
    ST_FAULT = 3'd5
`endif
  } state_t;

  // ALU-class opcodes (low four bits of an ALU-class instruction)
  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_AND     = 4'h2;
  localparam logic [3:0] OP_OR      = 4'h3;
  localparam logic [3:0] OP_XOR     = 4'h4;
  localparam logic [3:0] OP_SHL_A   = 4'h5;
  localparam logic [3:0] OP_SHR_A   = 4'h6;
  localparam logic [3:0] OP_INC_A   = 4'h7;
  localparam logic [3:0] OP_DEC_A   = 4'h8;
  localparam logic [3:0] OP_MOVE_AX = 4'h9;
  localparam logic [3:0] OP_MOVE_XA = 4'hA;
  localparam logic [3:0] OP_PASS_A  = 4'hB;
  localparam logic [3:0] OP_PASS_B  = 4'hC;

  // Control-class opcodes; 8..F decode as NOP
  localparam logic [3:0] CT_LDA  = 4'h0;
  localparam logic [3:0] CT_STA  = 4'h1;
  localparam logic [3:0] CT_JMP  = 4'h2;
  localparam logic [3:0] CT_BZ   = 4'h3;
  localparam logic [3:0] CT_BC   = 4'h4;
  localparam logic [3:0] CT_BN   = 4'h5;
  localparam logic [3:0] CT_BV   = 4'h6;
  localparam logic [3:0] CT_HALT = 4'h7;

  typedef enum logic [1:0] {
    WT_NONE = 2'd0,
    WT_A    = 2'd1,
    WT_X    = 2'd2
  } wr_tgt_t;

  function automatic logic alu_op_defined(input logic [3:0] op);
    return (op <= OP_PASS_B);
  endfunction

  function automatic wr_tgt_t alu_wr_target(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL_A, OP_SHR_A, OP_INC_A, OP_DEC_A, OP_MOVE_AX: return WT_A;
      OP_MOVE_XA:                                         return WT_X;
      default:                                            return WT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_mem_timer.sv
// Memory-phase timeout counter; built only when CPU_CTRL_TIMEOUT_EN is defined.
// Flags expiry on the last MEM cycle so an ack in that same cycle still wins.
`ifdef CPU_CTRL_TIMEOUT_EN
module cpu_ctrl_mem_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expire
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside MEM, so every MEM entry starts from a clean count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_active) begin
      r_cnt <= '0;
    end else if (!i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_active && (r_cnt == LAST);

endmodule
`endif

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 8-bit CPU: IDLE/FETCH/EXEC/MEM/HALT with run and
// single-step modes. CPU_CTRL_TIMEOUT_EN adds a MEM timeout leading to FAULT.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             exec_enable_i,
  input  logic [OPC_W-1:0] operation_i,
  input  logic             z_i,
  input  logic             c_i,
  input  logic             v_i,
  input  logic             n_i,
  input  logic             mem_ack_i,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic             ir_load_o,
  output logic [3:0]       alu_op_o,
  output logic             write_enable_a_o,
  output logic             write_enable_x_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             fault_o
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_exec_d;
  logic       w_start;
  logic       w_is_ctrl;
  logic [3:0] w_low;
  logic       w_is_mem_op;
  logic       w_is_store;
  logic       w_branch_taken;
  logic       w_timeout;
  wr_tgt_t    w_tgt;

  assign w_start     = exec_enable_i & ~r_exec_d;
  assign w_is_ctrl   = operation_i[OPC_W-1];
  assign w_low       = operation_i[3:0];
  assign w_is_mem_op = (w_low == CT_LDA) || (w_low == CT_STA);
  assign w_is_store  = (w_low == CT_STA);
  assign w_tgt       = alu_wr_target(w_low);

  always_comb begin
    w_branch_taken = 1'b0;
    case (w_low)
      CT_JMP:  w_branch_taken = 1'b1;
      CT_BZ:   w_branch_taken = z_i;
      CT_BC:   w_branch_taken = c_i;
      CT_BN:   w_branch_taken = n_i;
      CT_BV:   w_branch_taken = v_i;
      default: w_branch_taken = 1'b0;
    endcase
  end

`ifdef CPU_CTRL_TIMEOUT_EN
  cpu_ctrl_mem_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_mem_timer (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_active (r_state == ST_MEM),
    .i_ack    (mem_ack_i),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exec_d <= 1'b0;
    end else begin
      r_exec_d <= exec_enable_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run_i || w_start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_is_ctrl && w_is_mem_op)            w_state_next = ST_MEM;
        else if (w_is_ctrl && w_low == CT_HALT)  w_state_next = ST_HALT;
        else                                     w_state_next = run_i ? ST_FETCH : ST_IDLE;
      end
      ST_MEM: begin
        // An ack takes priority over a timeout expiring in the same cycle
        if (mem_ack_i) begin
          w_state_next = run_i ? ST_FETCH : ST_IDLE;
        end else if (w_timeout) begin
`ifdef CPU_CTRL_TIMEOUT_EN
          w_state_next = ST_FAULT;
`else
          w_state_next = ST_MEM;
`endif
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
`ifdef CPU_CTRL_TIMEOUT_EN
      ST_FAULT: begin
        w_state_next = ST_FAULT;
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_inc_o         = 1'b0;
    pc_load_o        = 1'b0;
    ir_load_o        = 1'b0;
    alu_op_o         = 4'h0;
    write_enable_a_o = 1'b0;
    write_enable_x_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    busy_o           = 1'b0;
    halted_o         = 1'b0;
    fault_o          = 1'b0;
    case (r_state)
      ST_FETCH: begin
        busy_o    = 1'b1;
        ir_load_o = 1'b1;
        pc_inc_o  = 1'b1;
      end
      ST_EXEC: begin
        busy_o = 1'b1;
        if (!w_is_ctrl) begin
          if (alu_op_defined(w_low)) begin
            alu_op_o         = w_low;
            write_enable_a_o = (w_tgt == WT_A);
            write_enable_x_o = (w_tgt == WT_X);
          end
        end else begin
          pc_load_o = w_branch_taken;
        end
      end
      ST_MEM: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = w_is_store;
        if (mem_ack_i && !w_is_store) begin
          write_enable_a_o = 1'b1;
          alu_op_o         = OP_PASS_B;
        end
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
`ifdef CPU_CTRL_TIMEOUT_EN
      ST_FAULT: begin
        fault_o = 1'b1;
      end
`endif
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: per-cycle expected output vectors are queued
// as stimulus is applied and compared as each cycle's outputs settle.
module tb_cpu_ctrl_seq;
  import cpu_pkg::*;

  localparam int OPC_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             en  = 1'b0;
  logic             z = 1'b0, c = 1'b0, v = 1'b0, n = 1'b0;
  logic             ack = 1'b0;
  logic [OPC_W-1:0] op = '0;

  logic       pc_inc, pc_load, ir_load, we_a, we_x, mem_req, mem_we, busy, halted, fault;
  logic [3:0] alu_op;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  string       q_tag[$];
  logic [13:0] q_exp[$];

  always #5 clk = ~clk;

  cpu_ctrl_seq #(
    .OPC_W       (OPC_W),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .run_i            (run),
    .exec_enable_i    (en),
    .operation_i      (op),
    .z_i              (z),
    .c_i              (c),
    .v_i              (v),
    .n_i              (n),
    .mem_ack_i        (ack),
    .pc_inc_o         (pc_inc),
    .pc_load_o        (pc_load),
    .ir_load_o        (ir_load),
    .alu_op_o         (alu_op),
    .write_enable_a_o (we_a),
    .write_enable_x_o (we_x),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .busy_o           (busy),
    .halted_o         (halted),
    .fault_o          (fault)
  );

  wire [13:0] w_obs = {pc_inc, pc_load, ir_load, alu_op, we_a, we_x,
                       mem_req, mem_we, busy, halted, fault};

  function automatic logic [13:0] mk(input logic pi, input logic pl, input logic ir,
                                     input logic [3:0] a, input logic wa, input logic wx,
                                     input logic mr, input logic mw, input logic b,
                                     input logic h, input logic f);
    return {pi, pl, ir, a, wa, wx, mr, mw, b, h, f};
  endfunction

  function automatic logic [13:0] v_fetch();
    return mk(1, 0, 1, 4'h0, 0, 0, 0, 0, 1, 0, 0);
  endfunction

  function automatic logic [13:0] v_alu(input logic [3:0] a, input logic wa, input logic wx);
    return mk(0, 0, 0, a, wa, wx, 0, 0, 1, 0, 0);
  endfunction

  function automatic logic [13:0] v_ctl(input logic pl);
    return mk(0, pl, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0);
  endfunction

  function automatic logic [13:0] v_mem(input logic mw, input logic lda_ack);
    return mk(0, 0, 0, lda_ack ? OP_PASS_B : 4'h0, lda_ack, 0, 1, mw, 1, 0, 0);
  endfunction

  task automatic check_front();
    string       t;
    logic [13:0] e;
    t = q_tag.pop_front();
    e = q_exp.pop_front();
    n_total++;
    assert (w_obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, w_obs, e);
    end
    $display("check %s obs=%h exp=%h", t, w_obs, e);
  endtask

  // One clock cycle: queue expectation, compare at negedge, advance past posedge
  task automatic cyc(input string tag, input logic [13:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  task automatic now(input string tag, input logic [13:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
    #1;
    check_front();
  endtask

  task automatic step_start(input string tag);
    en = 1'b1;
    cyc({tag, "_idle"}, '0);
    en = 1'b0;
    cyc({tag, "_fetch"}, v_fetch());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    now("reset", '0);
    rst = 1'b0;

    // Single step ADD, holding exec_enable high afterwards
    op = {1'b0, OP_ADD};
    en = 1'b1;
    cyc("add_idle", '0);
    cyc("add_fetch", v_fetch());
    cyc("add_exec", v_alu(OP_ADD, 1, 0));
    cyc("add_hold1", '0);
    cyc("add_hold2", '0);
    en = 1'b0;
    cyc("add_release", '0);

    // Run mode, back-to-back; drop run during second instruction
    run = 1'b1;
    op  = {1'b0, OP_MOVE_XA};
    cyc("run_idle", '0);
    cyc("run_fetch1", v_fetch());
    cyc("run_movxa", v_alu(OP_MOVE_XA, 0, 1));
    op  = {1'b0, OP_PASS_A};
    run = 1'b0;
    cyc("run_fetch2", v_fetch());
    cyc("run_pass_a", v_alu(OP_PASS_A, 0, 0));
    cyc("run_stop", '0);

    // Branches, NOP, undefined ALU op
    op = 5'b10011; z = 0;
    step_start("bz0");  cyc("bz0_exec", v_ctl(0));
    z = 1;
    step_start("bz1");  cyc("bz1_exec", v_ctl(1));
    z = 0; c = 0; v = 0; n = 0; op = 5'b10010;
    step_start("jmp");  cyc("jmp_exec", v_ctl(1));
    op = 5'b10100; c = 1;
    step_start("bc1");  cyc("bc1_exec", v_ctl(1));
    op = 5'b10101; z = 1; n = 0;
    step_start("bn0");  cyc("bn0_exec", v_ctl(0));
    op = 5'b10110; v = 1;
    step_start("bv1");  cyc("bv1_exec", v_ctl(1));
    op = 5'b11000; z = 1; c = 1; v = 1; n = 1;
    step_start("nop");  cyc("nop_exec", v_ctl(0));
    z = 0; c = 0; v = 0; n = 0; op = 5'b01101;
    step_start("undef"); cyc("undef_exec", v_alu(4'h0, 0, 0));

    // LDA with ack on third MEM cycle
    op = 5'b10000;
    step_start("lda");
    cyc("lda_exec", v_ctl(0));
    cyc("lda_mem1", v_mem(0, 0));
    cyc("lda_mem2", v_mem(0, 0));
    ack = 1'b1;
    cyc("lda_mem3_ack", v_mem(0, 1));
    cyc("ack_idle_ignored1", '0);
    cyc("ack_idle_ignored2", '0);
    ack = 1'b0;

    // STA zero-wait
    op = 5'b10001;
    step_start("sta");
    cyc("sta_exec", v_ctl(0));
    ack = 1'b1;
    cyc("sta_mem_ack", v_mem(1, 0));
    ack = 1'b0;
    cyc("sta_done", '0);

    // HALT ignores start pulses and run
    op = 5'b10111;
    step_start("halt");
    cyc("halt_exec", v_ctl(0));
    cyc("halt_state", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    en = 1'b1;
    cyc("halt_pulse", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    en = 1'b0; run = 1'b1;
    cyc("halt_run1", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    cyc("halt_run2", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    run = 1'b0;
    rst = 1'b1;
    now("halt_reset", '0);
    rst = 1'b0;
    cyc("after_halt_idle", '0);

    // Reset in the middle of a memory phase
    op = 5'b10000;
    step_start("rmem");
    cyc("rmem_exec", v_ctl(0));
    cyc("rmem_mem1", v_mem(0, 0));
`ifndef CPU_CTRL_TIMEOUT_EN
    for (int i = 0; i < 6; i++) cyc($sformatf("rmem_wait%0d", i), v_mem(0, 0));
`endif
    rst = 1'b1;
    now("rmem_reset", '0);
    rst = 1'b0;
    cyc("rmem_idle1", '0);
    cyc("rmem_idle2", '0);

`ifdef CPU_CTRL_TIMEOUT_EN
    // Timeout without ack leads to FAULT after four MEM cycles
    step_start("to");
    cyc("to_exec", v_ctl(0));
    for (int i = 1; i <= 4; i++) cyc($sformatf("to_mem%0d", i), v_mem(0, 0));
    cyc("to_fault1", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1));
    en = 1'b1; ack = 1'b1;
    cyc("to_fault2", mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1));
    en = 1'b0; ack = 1'b0;
    rst = 1'b1;
    now("to_reset", '0);
    rst = 1'b0;
    // Ack in the expiry cycle completes normally
    step_start("toack");
    cyc("toack_exec", v_ctl(0));
    for (int i = 1; i <= 3; i++) cyc($sformatf("toack_mem%0d", i), v_mem(0, 0));
    ack = 1'b1;
    cyc("toack_mem4_ack", v_mem(0, 1));
    ack = 1'b0;
    cyc("toack_idle", '0);
    cyc("toack_idle2", '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
